// File: rtl/random_source.sv
// Random-interval valid/ready stream source with an incrementing (or LFSR) payload.
// Optional feature: define RANDOM_SOURCE_LFSR_DATA_EN to send LFSR bits instead of the word counter.
module random_source #(
    parameter int          BITS  = 8,
    parameter int          SPEED = 2,
    parameter int          COUNT = 0,
    parameter logic [63:0] SEED  = 64'h1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    output logic            valid,
    input  logic            ready,
    output logic [BITS-1:0] data,
    output logic [31:0]     sent,
    output logic            done
);

    localparam logic [63:0] TAPS     = 64'h8000_0000_0000_19E2;
    // SPEED == 0 gives an empty mask, so every cycle counts as a hit.
    localparam logic [63:0] HIT_MASK = (SPEED == 0) ? 64'd0 : ((64'd1 << SPEED) - 64'd1);
    localparam logic [31:0] COUNT_W  = 32'(COUNT);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     lfsr_q, lfsr_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] data_q, data_d;
    logic [31:0]     sent_q, sent_d;
    logic            done_q, done_d;

    logic            hit;
    logic [31:0]     sentInc;
    logic [31:0]     nextSent;
    logic [BITS-1:0] loadWord;

    always_comb begin
        lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        hit      = ((lfsr_q & HIT_MASK) == 64'd0);
        sentInc  = sent_q + 32'd1;
        nextSent = ((state_q == OFFER) && ready) ? sentInc : sent_q;
`ifdef RANDOM_SOURCE_LFSR_DATA_EN
        loadWord = BITS'(lfsr_q);
`else
        loadWord = BITS'(nextSent);
`endif

        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        sent_d  = sent_q;
        done_d  = done_q;

        // A held offer only ever ends through a transfer; enable just gates the next load.
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (enable && hit) begin
                    state_d = OFFER;
                    valid_d = 1'b1;
                    data_d  = loadWord;
                end
            end
            OFFER: begin
                if (ready) begin
                    sent_d = sentInc;
                    if ((COUNT != 0) && (sentInc == COUNT_W)) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (enable && hit) begin
                        data_d = loadWord;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            data_q  <= '0;
            sent_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign sent  = sent_q;
    assign done  = done_q;

endmodule

// File: tb/tb_random_source.sv
// Scoreboard bench for random_source: three instances cover free-running, COUNT-bounded and random-gap streams.
module tb_random_source;

    localparam int          BITS = 8;
    localparam logic [63:0] SEED = 64'h1;
    localparam logic [63:0] TAPS = 64'h8000_0000_0000_19E2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en0 = 1'b0, rdy0 = 1'b0;
    logic en1 = 1'b0, rdy1 = 1'b0;
    logic en2 = 1'b0, rdy2 = 1'b0;

    logic            valid0, valid1, valid2;
    logic [BITS-1:0] data0, data1, data2;
    logic [31:0]     sent0, sent1, sent2;
    logic            done0, done1, done2;

    int tests    = 0;
    int failures = 0;

    logic [63:0]     refLfsr, refPrev;
    logic [BITS-1:0] expQ[$];
    logic [BITS-1:0] expWordHeld;
    logic [BITS-1:0] popped;

    logic            prevValid, prevEn, prevRdy, xfer;
    logic [BITS-1:0] prevData;
    int              loadIdx, xfers;

    random_source #(.BITS(BITS), .SPEED(0), .COUNT(0), .SEED(SEED)) u0 (
        .clk(clk), .rst(rst), .enable(en0), .valid(valid0), .ready(rdy0),
        .data(data0), .sent(sent0), .done(done0)
    );

    random_source #(.BITS(BITS), .SPEED(0), .COUNT(4), .SEED(SEED)) u1 (
        .clk(clk), .rst(rst), .enable(en1), .valid(valid1), .ready(rdy1),
        .data(data1), .sent(sent1), .done(done1)
    );

    random_source #(.BITS(BITS), .SPEED(2), .COUNT(0), .SEED(SEED)) u2 (
        .clk(clk), .rst(rst), .enable(en2), .valid(valid2), .ready(rdy2),
        .data(data2), .sent(sent2), .done(done2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsrStep(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // refPrev holds the LFSR state that was current at the most recent rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            refLfsr <= SEED;
            refPrev <= SEED;
        end else begin
            refPrev <= refLfsr;
            refLfsr <= lfsrStep(refLfsr);
        end
    end

    // Word that the next rising edge should load, given it is the k-th word of the stream.
    function automatic logic [BITS-1:0] expWord(input int k);
`ifdef RANDOM_SOURCE_LFSR_DATA_EN
        return refLfsr[BITS-1:0];
`else
        return BITS'(k);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic popCheck(input string tag, input logic [BITS-1:0] obs);
        logic [BITS-1:0] e;
        e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
        checkOutput(tag, obs, e);
    endtask

    // Holds reset across a negedge, drops all inputs and checks every instance's reset state.
    task automatic applyStimulus();
        rst  = 1'b1;
        en0  = 1'b0; rdy0 = 1'b0;
        en1  = 1'b0; rdy1 = 1'b0;
        en2  = 1'b0; rdy2 = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("reset valid", {valid0, valid1, valid2}, 3'b000);
        checkOutput("reset done", {done0, done1, done2}, 3'b000);
        checkOutput("reset data0", data0, 0);
        checkOutput("reset data2", data2, 0);
        checkOutput("reset sent0", sent0, 0);
        checkOutput("reset sent1", sent1, 0);
    endtask

    initial begin
        // Free-running stream: one word per cycle, payload wraps after 255.
        applyStimulus();
        en0 = 1'b1; rdy0 = 1'b1; rst = 1'b0;
        for (int k = 0; k < 257; k++) begin
            expQ.push_back(expWord(k));
            @(negedge clk);
            checkOutput("stream valid", valid0, 1);
            popCheck("stream data", data0);
        end
        @(negedge clk);
        checkOutput("stream sent", sent0, 257);
        checkOutput("stream done", done0, 0);

        // COUNT=4: four words, then done with valid low and sent frozen.
        applyStimulus();
        en1 = 1'b1; rdy1 = 1'b1; rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expQ.push_back(expWord(k));
            @(negedge clk);
            checkOutput("count valid", valid1, 1);
            checkOutput("count done early", done1, 0);
            popCheck("count data", data1);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checkOutput("count done", done1, 1);
            checkOutput("count valid off", valid1, 0);
            checkOutput("count sent", sent1, 4);
        end

        // Backpressure: the first word must hold for ten cycles, then transfer once.
        applyStimulus();
        en0 = 1'b1; rdy0 = 1'b0;
        expWordHeld = expWord(0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold valid", valid0, 1);
            checkOutput("hold data", data0, expWordHeld);
            checkOutput("hold sent", sent0, 0);
        end
        rdy0 = 1'b1; en0 = 1'b0;
        @(negedge clk);
        checkOutput("single xfer sent", sent0, 1);
        checkOutput("single xfer valid", valid0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("single xfer stays", sent0, 1);
        end

        // Reset in the middle of an offer of word 5.
        applyStimulus();
        en0 = 1'b1; rdy0 = 1'b1; rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expQ.push_back(expWord(k));
            @(negedge clk);
            popCheck("pre-reset data", data0);
        end
        checkOutput("pre-reset valid", valid0, 1);
        rdy0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst valid", valid0, 0);
        checkOutput("async rst data", data0, 0);
        checkOutput("async rst sent", sent0, 0);
        @(negedge clk);
        rdy0 = 1'b1;
        expQ.delete();
        rst = 1'b0;
        expQ.push_back(expWord(0));
        @(negedge clk);
        checkOutput("restart valid", valid0, 1);
        popCheck("restart data", data0);

        // Random enable and ready against the SPEED=2 instance.
        applyStimulus();
        en2 = ($urandom_range(0, 3) != 0);
        rdy2 = $urandom_range(0, 1);
        rst = 1'b0;
        prevValid = 1'b0; prevData = '0; prevEn = en2; prevRdy = rdy2;
        loadIdx = 0; xfers = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            xfer = prevValid && prevRdy;
            if (prevValid && !prevRdy) begin
                checkOutput("random hold valid", valid2, 1);
                checkOutput("random hold data", data2, prevData);
            end
            if (xfer) begin
                xfers++;
                popCheck("random order", prevData);
            end
            if (!prevValid || xfer) begin
                checkOutput("random offer start", valid2, prevEn && (refPrev[1:0] == 2'b00));
                if (valid2) begin
`ifdef RANDOM_SOURCE_LFSR_DATA_EN
                    expQ.push_back(refPrev[BITS-1:0]);
`else
                    expQ.push_back(BITS'(loadIdx));
`endif
                    loadIdx++;
                end
            end
            prevValid = valid2;
            prevData  = data2;
            en2  = ($urandom_range(0, 3) != 0);
            rdy2 = $urandom_range(0, 1);
            prevEn  = en2;
            prevRdy = rdy2;
        end
        checkOutput("random sent total", sent2, xfers);
        checkOutput("random done", done2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
